// File: rtl/l1c_pkg.sv
// Shared definitions for the associative instruction cache.
// Holds the controller state encoding, address-field width helpers and the
// tree-PLRU victim/update functions (up to 4 ways, packed into 3 bits).
package l1c_pkg;

  typedef enum logic [1:0] {StIdle, StLookup, StRefill, StResp} state_e;

  localparam int unsigned AddrW = 32;

  function automatic int unsigned off_bits(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned line_words);
    return AddrW - off_bits(line_words) - idx_bits(sets);
  endfunction

  // Each tree bit points at the less recently used side.
  // 4 ways: bit0 picks pair {0,1} vs {2,3}, bit1 picks within {0,1}, bit2 within {2,3}.
  function automatic logic [1:0] plru_victim(input int unsigned ways, input logic [2:0] bits);
    if (ways == 4) begin
      return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    end else if (ways == 2) begin
      return {1'b0, bits[0]};
    end
    return 2'd0;
  endfunction

  // Make 'way' most recently used: point every bit on its path away from it.
  function automatic logic [2:0] plru_update(input int unsigned ways, input logic [2:0] bits,
                                             input logic [1:0] way);
    logic [2:0] r;
    r = bits;
    if (ways == 4) begin
      r[0] = ~way[1];
      if (way[1]) r[2] = ~way[0];
      else        r[1] = ~way[0];
    end else if (ways == 2) begin
      r[0] = ~way[0];
    end
    return r;
  endfunction

endpackage

// File: rtl/l1c_way.sv
// One way of the instruction cache: tag, valid and line data storage.
// Writes are synchronous, reads combinational.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears valid bits)
//   clear            invalidate every set of this way on the next edge
//   rd_idx, rd_word  read set index and word within line
//   rd_tag, rd_valid, rd_data  read results
//   data_we, wr_idx, wr_word, wr_data  data word write
//   tag_we, wr_tag   write tag of set wr_idx and mark it valid
module l1c_way #(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 22,
  localparam int unsigned IdxW      = $clog2(SETS),
  localparam int unsigned WordW     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [IdxW-1:0]  rd_idx,
  input  logic [WordW-1:0] rd_word,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  input  logic             data_we,
  input  logic [IdxW-1:0]  wr_idx,
  input  logic [WordW-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[wr_idx] <= wr_tag;
    if (data_we) data_q[{wr_idx, wr_word}] <= wr_data;
  end

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_data  = data_q[{rd_idx, rd_word}];

endmodule

// File: rtl/l1c_inst_assoc.sv
// Set-associative, read-only instruction cache with tree-PLRU replacement.
// A fetch takes one IDLE cycle to register the address, one LOOKUP cycle
// (hit answers here), then on a miss a burst refill and a RESP cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   core_req, core_addr       fetch request and byte address (word aligned)
//   core_out, core_wait       fetched word and stall
//   flush                     invalidate all lines
//   mem_req, mem_addr         refill beat request and word address
//   mem_rdata, mem_wait       refill data and beat stall
//   hit_cnt, miss_cnt         saturating hit/miss counters
module l1c_inst_assoc
  import l1c_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  output logic [31:0] core_out,
  output logic        core_wait,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_wait,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned WordW = off_bits(LINE_WORDS) - 2;
  localparam int unsigned IdxW  = idx_bits(SETS);
  localparam int unsigned TagW  = tag_bits(SETS, LINE_WORDS);
  localparam int unsigned WayW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned PlruW = (WAYS > 1) ? WAYS - 1 : 1;

  state_e             state_q, state_d;
  logic [29:0]        addr_q, addr_d;  // word address of the current fetch
  logic [WordW-1:0]   beat_q, beat_d;
  logic [WayW-1:0]    victim_q, victim_d;
  logic               flush_pend_q, flush_pend_d;
  logic               after_rst_q;
  logic [31:0]        hit_cnt_q, miss_cnt_q;
  logic [PlruW-1:0]   plru_q [SETS];

  logic [TagW-1:0]    req_tag;
  logic [IdxW-1:0]    req_idx;
  logic [WordW-1:0]   req_word;

  logic [TagW-1:0]    way_tag   [WAYS];
  logic               way_valid [WAYS];
  logic [31:0]        way_data  [WAYS];

  logic               hit;
  logic [WayW-1:0]    hit_way;
  logic [WayW-1:0]    victim;
  logic               data_we, tag_we, flush_clr;
  logic               hit_inc, miss_inc;
  logic               plru_we;
  logic [WayW-1:0]    plru_way;
  logic               unused_addr;

  assign unused_addr = ^core_addr[1:0];

  assign req_word = addr_q[0 +: WordW];
  assign req_idx  = addr_q[WordW +: IdxW];
  assign req_tag  = addr_q[29 -: TagW];

  for (genvar g = 0; g < WAYS; g++) begin : gen_way
    l1c_way #(
      .SETS      (SETS),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TagW)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush_clr),
      .rd_idx  (req_idx),
      .rd_word (req_word),
      .rd_tag  (way_tag[g]),
      .rd_valid(way_valid[g]),
      .rd_data (way_data[g]),
      .data_we (data_we && (victim_q == WayW'(g))),
      .wr_idx  (req_idx),
      .wr_word (beat_q),
      .wr_data (mem_rdata),
      .tag_we  (tag_we && (victim_q == WayW'(g))),
      .wr_tag  (req_tag)
    );
  end

  // Tag match, and victim choice: lowest invalid way first, else PLRU.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = WayW'(plru_victim(WAYS, 3'(plru_q[req_idx])));
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && way_valid[w] && (way_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WayW'(w);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    victim_d     = victim_q;
    flush_pend_d = flush_pend_q | flush;
    core_wait    = 1'b1;
    core_out     = '0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    flush_clr    = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    plru_we      = 1'b0;
    plru_way     = hit_way;
    unique case (state_q)
      StIdle: begin
        if (after_rst_q) begin
          // Quiet cycle after reset: stall released, no request accepted yet.
          core_wait = 1'b0;
        end else if (flush || flush_pend_q) begin
          flush_clr    = 1'b1;
          flush_pend_d = 1'b0;
        end else if (core_req) begin
          addr_d  = core_addr[31:2];
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          core_wait = 1'b0;
          core_out  = way_data[hit_way];
          hit_inc   = 1'b1;
          plru_we   = 1'b1;
          state_d   = StIdle;
        end else begin
          miss_inc = 1'b1;
          victim_d = victim;
          beat_d   = '0;
          state_d  = StRefill;
        end
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, beat_q, 2'b00};
        if (!mem_wait) begin
          data_we = 1'b1;
          if (beat_q == WordW'(LINE_WORDS - 1)) begin
            tag_we   = 1'b1;
            plru_we  = 1'b1;
            plru_way = victim_q;
            state_d  = StResp;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StResp: begin
        core_wait = 1'b0;
        core_out  = way_data[victim_q];
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    after_rst_q <= rst;
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      beat_q       <= '0;
      victim_q     <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      victim_q     <= victim_d;
      flush_pend_q <= flush_pend_d;
      if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_clr) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (plru_we) begin
      plru_q[req_idx] <= PlruW'(plru_update(WAYS, 3'(plru_q[req_idx]), 2'(plru_way)));
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_l1c_inst_assoc.sv
// Directed bench for l1c_inst_assoc with default parameters (2 ways,
// 64 sets, 4-word lines). Memory returns word_of(addr) for every beat.
module tb_l1c_inst_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_out;
  logic        core_wait;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_wait = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int quiet_bad = 0;

  // Configuration written only by the main process.
  int          cfg_seq = 0;
  logic [31:0] cfg_stall_addr = '0;
  int          cfg_stall_n = 0;
  logic [31:0] cfg_flush_addr = '0;

  // Memory-side bookkeeping written only by the monitor.
  int          seen_seq = 0;
  int          stall_left = 0;
  bit          flush_armed = 1'b0;
  int          stall_seen = 0;
  int          req_cycles = 0;
  logic [31:0] beats [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  assign mem_rdata = word_of(mem_addr);

  l1c_inst_assoc dut (
    .clk      (clk),
    .rst      (rst),
    .core_req (core_req),
    .core_addr(core_addr),
    .core_out (core_out),
    .core_wait(core_wait),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wait (mem_wait),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  // Memory model: stalls a chosen beat, fires a one-cycle flush on a chosen beat.
  always @(negedge clk) begin
    if (cfg_seq != seen_seq) begin
      seen_seq    = cfg_seq;
      stall_left  = cfg_stall_n;
      flush_armed = (cfg_flush_addr != 32'd0);
    end
    if (mem_req && (mem_addr == cfg_stall_addr) && (stall_left > 0)) begin
      mem_wait = 1'b1;
      stall_left--;
      if (core_wait) stall_seen++;
    end else begin
      mem_wait = 1'b0;
    end
    if (mem_req && !mem_wait) beats.push_back(mem_addr);
    if (mem_req) req_cycles++;
    if (flush_armed && mem_req && (mem_addr == cfg_flush_addr)) begin
      flush       = 1'b1;
      flush_armed = 1'b0;
    end else begin
      flush = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic configure(input logic [31:0] stall_addr, input int stall_n,
                           input logic [31:0] flush_addr);
    cfg_stall_addr = stall_addr;
    cfg_stall_n    = stall_n;
    cfg_flush_addr = flush_addr;
    cfg_seq++;
  endtask

  // Starts and ends at posedge+1.
  task automatic do_reset(input string tag);
    rst      = 1'b1;
    core_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq({tag, "_wait"}, 32'(core_wait), 32'd0);
    check_eq({tag, "_mreq"}, 32'(mem_req), 32'd0);
    check_eq({tag, "_hits"}, hit_cnt, 32'd0);
    check_eq({tag, "_miss"}, miss_cnt, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Holds the request until core_wait drops; cycles counts from the IDLE cycle.
  task automatic fetch(input logic [31:0] a, output logic [31:0] data, output int cycles);
    bit done;
    core_req = 1'b1;
    core_addr = a;
    cycles = 0;
    data = '0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      cycles++;
      if (core_wait) begin
        if (core_out != 32'd0) quiet_bad++;
      end else begin
        data = core_out;
        done = 1'b1;
      end
    end
    check_eq("fetch_done", 32'(done), 32'd1);
    @(posedge clk);
    #1 core_req = 1'b0;
  endtask

  logic [31:0] d;
  int          n;
  int          b0, r0, s0;

  initial begin
    configure(32'd0, 0, 32'd0);

    // Cold miss on 0x1004.
    do_reset("rst0");
    b0 = beats.size();
    fetch(32'h0000_1004, d, n);
    check_eq("cold_data", d, 32'hCEA9_BEEF);
    check_eq("cold_cycles", 32'(n), 32'd7);
    check_eq("cold_miss", miss_cnt, 32'd1);
    check_eq("cold_beats", 32'(beats.size() - b0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("cold_beat%0d", i), beats[b0 + i], 32'h1000 + 32'(4 * i));
    end

    // Hit in the same line.
    r0 = req_cycles;
    fetch(32'h0000_100C, d, n);
    check_eq("hit_data", d, 32'hCEA1_BEEF);
    check_eq("hit_cycles", 32'(n), 32'd2);
    check_eq("hit_no_mem", 32'(req_cycles - r0), 32'd0);
    check_eq("hit_cnt", hit_cnt, 32'd1);

    // PLRU eviction in set 0.
    do_reset("rst1");
    fetch(32'h0000_1000, d, n);
    check_eq("lru_a_cycles", 32'(n), 32'd7);
    fetch(32'h0000_2000, d, n);
    check_eq("lru_b_cycles", 32'(n), 32'd7);
    check_eq("lru_b_data", d, word_of(32'h2000));
    fetch(32'h0000_1000, d, n);
    check_eq("lru_a_hit", 32'(n), 32'd2);
    fetch(32'h0000_3000, d, n);
    check_eq("lru_c_cycles", 32'(n), 32'd7);
    check_eq("lru_c_data", d, word_of(32'h3000));
    fetch(32'h0000_1000, d, n);
    check_eq("lru_a_kept", 32'(n), 32'd2);
    check_eq("lru_a_data", d, word_of(32'h1000));
    fetch(32'h0000_2000, d, n);
    check_eq("lru_b_evicted", 32'(n), 32'd7);
    check_eq("lru_hits", hit_cnt, 32'd2);
    check_eq("lru_misses", miss_cnt, 32'd4);

    // Memory stall on the 0x1008 beat.
    do_reset("rst2");
    configure(32'h0000_1008, 3, 32'd0);
    s0 = stall_seen;
    b0 = beats.size();
    fetch(32'h0000_1000, d, n);
    check_eq("stall_cycles", 32'(n), 32'd10);
    check_eq("stall_data", d, word_of(32'h1000));
    check_eq("stall_held", 32'(stall_seen - s0), 32'd3);
    check_eq("stall_beat2", beats[b0 + 2], 32'h1008);
    check_eq("stall_beat3", beats[b0 + 3], 32'h100C);
    fetch(32'h0000_1008, d, n);
    check_eq("stall_w2_hit", 32'(n), 32'd2);
    check_eq("stall_w2_data", d, word_of(32'h1008));
    fetch(32'h0000_100C, d, n);
    check_eq("stall_w3_data", d, word_of(32'h100C));

    // Flush during refill: access completes, line is gone afterwards.
    do_reset("rst3");
    configure(32'd0, 0, 32'h0000_1008);
    fetch(32'h0000_1000, d, n);
    check_eq("flush_data", d, word_of(32'h1000));
    check_eq("flush_cycles", 32'(n), 32'd7);
    fetch(32'h0000_1000, d, n);
    check_eq("flush_refetch", 32'(n), 32'd8);
    check_eq("flush_misses", miss_cnt, 32'd2);
    check_eq("flush_hits", hit_cnt, 32'd0);

    // Reset during the second refill beat.
    do_reset("rst4");
    configure(32'd0, 0, 32'd0);
    core_req  = 1'b1;
    core_addr = 32'h0000_1000;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req && (mem_addr == 32'h1004)) break;
    end
    check_eq("rst_mid_addr", mem_addr, 32'h1004);
    rst      = 1'b1;
    core_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_mreq", 32'(mem_req), 32'd0);
    check_eq("rst_mid_maddr", mem_addr, 32'd0);
    check_eq("rst_mid_wait", 32'(core_wait), 32'd0);
    check_eq("rst_mid_out", core_out, 32'd0);
    check_eq("rst_mid_miss", miss_cnt, 32'd0);
    @(posedge clk);
    #1;
    fetch(32'h0000_1000, d, n);
    check_eq("rst_mid_refetch", 32'(n), 32'd7);
    check_eq("rst_mid_data", d, word_of(32'h1000));
    check_eq("rst_mid_miss2", miss_cnt, 32'd1);

    check_eq("core_out_quiet", 32'(quiet_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1c_inst_assoc.md
L1C_INST_ASSOC -- requirements
Module: l1c_inst_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 SHALL have parameter SETS, default 64, sets per way; power of 2, at least 2.
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line; power of 2, at least 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port core_req  input  1  fetch request; held with core_addr until core_wait low.
REQ-007 SHALL have port core_addr  input  32  byte address of fetch, word aligned.
REQ-008 SHALL have port core_out  output  32  fetched instruction; valid only in the cycle core_wait is low with core_req high.
REQ-009 SHALL have port core_wait  output  1  stall to core.
REQ-010 SHALL have port flush  input  1  invalidate-all request; a single-cycle pulse is sufficient.
REQ-011 SHALL have port mem_req  output  1  memory read request.
REQ-012 SHALL have port mem_addr  output  32  word address of the current refill beat.
REQ-013 SHALL have port mem_rdata  input  32  refill data.
REQ-014 SHALL have port mem_wait  input  1  beat not yet accepted; a beat completes in a cycle with mem_req=1 and mem_wait=0.
REQ-015 SHALL have port hit_cnt  output  32  saturating count of hits.
REQ-016 SHALL have port miss_cnt  output  32  saturating count of misses.

Function
REQ-017 SHALL split the address into offset [log2(LINE_WORDS)+1:0], index (next log2(SETS) bits) and tag (remaining upper bits).
REQ-018 SHALL implement states IDLE, LOOKUP, REFILL, RESP.
REQ-019 SHALL, in IDLE with core_req=1 and no pending flush, register the address and enter LOOKUP; core_wait=1 in that cycle.
REQ-020 SHALL, in LOOKUP, compare the tag against all valid ways of the set; on a hit it drives core_out, sets core_wait=0, increments hit_cnt and returns to IDLE.
REQ-021 SHALL, in LOOKUP on a miss, increment miss_cnt, select a victim and enter REFILL.
REQ-022 SHALL select as victim the lowest-index invalid way, else the tree-PLRU way (WAYS-1 bits per set; WAYS=1 means way 0).
REQ-023 SHALL update the PLRU bits on every hit and every refill, so that the accessed way becomes most recently used.
REQ-024 SHALL, in REFILL, hold mem_req=1 and present line-aligned addresses base, base+4, ... in order; mem_addr SHALL stay stable while mem_wait=1.
REQ-025 SHALL write each accepted beat into the victim way, and write tag/valid on the last beat; it SHALL then drop mem_req and enter RESP.
REQ-026 SHALL, in RESP, drive the requested word, core_wait=0 and return to IDLE; the miss response comes 1 cycle after the last beat is accepted.
REQ-027 SHALL hold core_wait=1 in every state and cycle other than the LOOKUP-hit and RESP cycles.
REQ-028 SHALL, on flush in IDLE, clear all valid and PLRU bits on the next edge; core_wait stays 1 for any concurrent request, and the lookup starts the following cycle.
REQ-029 SHALL, on flush during LOOKUP/REFILL/RESP, latch it as pending, complete the current access and apply the flush upon return to IDLE.
REQ-030 SHALL saturate both counters at 0xFFFF_FFFF.
REQ-031 SHALL keep core_out=0 whenever core_wait=1.

Reset
REQ-032 SHALL, while rst=1, force IDLE and clear all valid bits, PLRU bits, pending flush, refill counter, hit_cnt and miss_cnt.
REQ-033 SHALL drive core_wait=0, mem_req=0, mem_addr=0 and core_out=0 in the cycle after reset, regardless of any access that was in flight; a refill in progress is abandoned without setting valid.

Structure
REQ-034 SHALL take state enum, address-field width functions and the PLRU update/victim functions from shared package l1c_pkg.
REQ-035 SHALL instantiate WAYS copies of sub-module l1c_way, one per way; each holds tag, valid and data storage with a synchronous write and a combinational read.

Verification
REQ-036 Cold miss on 0x0000_1004 (defaults) -> mem_addr 0x1000,0x1004,0x1008,0x100C; word of 0x1004 returned with core_wait=0 one cycle after the 4th beat; miss_cnt=1.
REQ-037 Then fetch 0x0000_100C -> hit with core_wait=0 in the 2nd cycle, no mem_req, hit_cnt=1.
REQ-038 Fill 0x1000 and 0x2000 (index 0), re-fetch 0x1000, then fetch 0x3000 -> 0x2000 is evicted; 0x1000 hits and 0x2000 misses.
REQ-039 mem_wait held high 3 cycles on the beat for 0x1008 -> mem_addr stays 0x1008 and core_wait stays 1 throughout; the line data is correct.
REQ-040 Flush pulse during the refill of 0x1000 -> the fetch still completes with correct data; a subsequent fetch of 0x1000 misses.
REQ-041 rst during the 2nd refill beat -> next cycle IDLE with mem_req=0 and counters=0; re-fetch of the same address misses.
